// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RV_NOP           = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]     pc;
        logic [XLEN-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead fetch buffer: head entry is visible whenever count is non-zero.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int depth = 4,
    localparam int AW    = $clog2(depth)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         head_valid,
    output logic [AW:0]  count
);

    fetch_entry_t   storage [depth];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_pop;

    assign head_valid = (count != '0);
    assign head       = storage[rd_ptr];
    assign do_pop     = pop & head_valid;

    // Pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            storage[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC-owning fetch stage: credit-limited word reads, fixed-latency return
// tracking, and a show-ahead buffer feeding decode; redirects kill everything.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          memory_size         = 1024,
    parameter int          memory_address_bits = $clog2(memory_size),
    parameter int          data_width          = 32,
    parameter int          read_latency        = 1,
    parameter int          fifo_depth          = 4,
    parameter logic [31:0] reset_pc            = DEFAULT_RESET_PC
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output logic                           mem_read_enable,
    output logic [memory_address_bits-3:0] mem_address,
    input  logic [data_width-1:0]          mem_read_data,
    input  logic                           redirect_valid,
    input  logic [31:0]                    redirect_pc,
    output logic                           instr_valid,
    input  logic                           instr_ready,
    output logic [data_width-1:0]          instr_data,
    output logic [31:0]                    instr_pc,
    output logic                           fetch_error
);

    localparam int CNT_W = $clog2(fifo_depth) + 1;
    localparam int CW    = $clog2(fifo_depth + read_latency + 1) + 1;

    if (read_latency < 1 || read_latency > 4) begin : g_bad_latency
        $error("instruction_fetch_unit: read_latency must be 1..4");
    end
    if (fifo_depth < read_latency + 1 || (fifo_depth & (fifo_depth - 1)) != 0) begin : g_bad_depth
        $error("instruction_fetch_unit: fifo_depth must be a power of 2 and >= read_latency+1");
    end
    if (data_width != XLEN) begin : g_bad_width
        $error("instruction_fetch_unit: data_width must match fetch_pkg::XLEN");
    end
    if (reset_pc[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("instruction_fetch_unit: reset_pc must be word aligned");
    end

    logic [31:0]             pc;
    logic [read_latency:1]   vld_pipe;
    logic [31:0]             pc_pipe [1:read_latency];
    logic [CW-1:0]           inflight_cnt;
    logic [CW-1:0]           used;
    logic [CNT_W-1:0]        fifo_count;
    logic                    pop;
    fetch_entry_t            push_entry;
    fetch_entry_t            head;
    logic                    head_valid;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 1; i <= read_latency; i++)
            inflight_cnt = inflight_cnt + CW'(vld_pipe[i]);
    end

    // Every buffered or outstanding word holds a credit, so the FIFO can never overflow.
    assign pop             = instr_valid & instr_ready;
    assign used            = CW'(fifo_count) + inflight_cnt - CW'(pop);
    assign mem_read_enable = rst_n & ~redirect_valid & (used < CW'(fifo_depth));
    assign mem_address     = pc[memory_address_bits-1:2];

    always_ff @(posedge clk) begin
        if (!rst_n)
            pc <= reset_pc;
        else if (redirect_valid)
            pc <= {redirect_pc[31:2], 2'b00};
        else if (mem_read_enable)
            pc <= pc + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || redirect_valid) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= mem_read_enable;
            for (int i = 2; i <= read_latency; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pc_pipe[1] <= pc;
        for (int i = 2; i <= read_latency; i++)
            pc_pipe[i] <= pc_pipe[i-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            fetch_error <= 1'b0;
        else
            fetch_error <= redirect_valid & (|redirect_pc[1:0]);
    end

    assign push_entry = '{pc: pc_pipe[read_latency], data: mem_read_data};

    fetch_fifo #(
        .depth (fifo_depth)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (vld_pipe[read_latency]),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .head_valid (head_valid),
        .count      (fifo_count)
    );

    assign instr_valid = head_valid;
    assign instr_data  = head_valid ? head.data : '0;
    assign instr_pc    = head_valid ? head.pc   : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: L=2, 4-entry buffer, 64-byte memory.
module tb_instruction_fetch_unit;

    localparam int LAT      = 2;
    localparam int DEPTH    = 4;
    localparam int MEM_SIZE = 64;
    localparam int AB       = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_read_enable;
    logic [AB-3:0] mem_address;
    logic [31:0]   mem_read_data;
    logic          redirect_valid = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [31:0]   instr_data;
    logic [31:0]   instr_pc;
    logic          fetch_error;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_q [LAT];

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .memory_size  (MEM_SIZE),
        .data_width   (32),
        .read_latency (LAT),
        .fifo_depth   (DEPTH),
        .reset_pc     (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read_enable (mem_read_enable),
        .mem_address     (mem_address),
        .mem_read_data   (mem_read_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_data      (instr_data),
        .instr_pc        (instr_pc),
        .fetch_error     (fetch_error)
    );

    function automatic logic [31:0] word_of(input logic [3:0] idx);
        return 32'hA500_0000 | {28'b0, idx};
    endfunction

    // Fixed-latency memory; unrequested slots return a poison word.
    always @(posedge clk) begin
        rd_q[0] <= mem_read_enable ? word_of(mem_address) : 32'hDEAD_BEEF;
        for (int i = 1; i < LAT; i++)
            rd_q[i] <= rd_q[i-1];
    end
    assign mem_read_data = rd_q[LAT-1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        instr_ready = 1'b1;
        step();
        step();
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        checks++; if (instr_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", instr_data); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", instr_pc); end
        checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", fetch_error); end
        checks++; if (mem_read_enable !== 1'b0) begin errors++; $display("FAIL reset_rden: got %b expected 0", mem_read_enable); end
        checks++; if (mem_address !== 4'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_address); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset();
        instr_ready = 1'b1;
        for (int c = 0; c <= 22; c++) begin
            #1;
            checks++; if (mem_read_enable !== 1'b1) begin errors++; $display("FAIL stream_rden c=%0d: got %b expected 1", c, mem_read_enable); end
            checks++; if (mem_address !== 4'(c)) begin errors++; $display("FAIL stream_addr c=%0d: got %h expected %h", c, mem_address, 4'(c)); end
            checks++; if (instr_valid !== (c >= 3)) begin errors++; $display("FAIL stream_valid c=%0d: got %b expected %b", c, instr_valid, (c >= 3)); end
            if (c >= 3) begin
                exp_pc = 32'((c - 3) * 4);
                checks++; if (instr_pc !== exp_pc) begin errors++; $display("FAIL stream_pc c=%0d: got %h expected %h", c, instr_pc, exp_pc); end
                checks++; if (instr_data !== word_of(4'(c - 3))) begin errors++; $display("FAIL stream_data c=%0d: got %h expected %h", c, instr_data, word_of(4'(c - 3))); end
            end else begin
                checks++; if (instr_data !== 32'h0) begin errors++; $display("FAIL stream_idle_data c=%0d: got %h expected 0", c, instr_data); end
            end
            step();
        end
    endtask

    task automatic test_stall();
        do_reset();
        instr_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            checks++; if (mem_read_enable !== (c < 4)) begin errors++; $display("FAIL stall_rden c=%0d: got %b expected %b", c, mem_read_enable, (c < 4)); end
            if (c >= 3) begin
                checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_data !== word_of(4'h0)) begin
                    errors++; $display("FAIL stall_hold c=%0d: got v=%b pc=%h d=%h expected v=1 pc=0 d=%h", c, instr_valid, instr_pc, instr_data, word_of(4'h0));
                end
            end
            step();
        end
        instr_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (k == 0) begin
                checks++; if (mem_read_enable !== 1'b1) begin errors++; $display("FAIL stall_release_rden: got %b expected 1", mem_read_enable); end
            end
            checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'(k * 4) || instr_data !== word_of(4'(k))) begin
                errors++; $display("FAIL stall_drain k=%0d: got v=%b pc=%h d=%h expected v=1 pc=%h d=%h", k, instr_valid, instr_pc, instr_data, 32'(k * 4), word_of(4'(k)));
            end
            step();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        instr_ready = 1'b1;
        redirect_pc = 32'h28;
        for (int c = 0; c <= 17; c++) begin
            redirect_valid = (c == 10);
            #1;
            if (c == 10) begin
                checks++; if (mem_read_enable !== 1'b0) begin errors++; $display("FAIL redir_rden: got %b expected 0", mem_read_enable); end
                checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h1C) begin errors++; $display("FAIL redir_same_cycle_pop: got v=%b pc=%h expected v=1 pc=0000001c", instr_valid, instr_pc); end
            end
            if (c == 11) begin
                checks++; if (mem_read_enable !== 1'b1 || mem_address !== 4'hA) begin errors++; $display("FAIL redir_first_req: got en=%b addr=%h expected en=1 addr=a", mem_read_enable, mem_address); end
                checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL redir_no_error: got %b expected 0", fetch_error); end
            end
            if (c >= 11 && c <= 13) begin
                checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_kill c=%0d: got v=%b pc=%h expected v=0", c, instr_valid, instr_pc); end
            end
            if (c >= 14) begin
                checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'(32'h28 + (c - 14) * 4) || instr_data !== word_of(4'(10 + c - 14))) begin
                    errors++; $display("FAIL redir_stream c=%0d: got v=%b pc=%h d=%h expected v=1 pc=%h d=%h", c, instr_valid, instr_pc, instr_data, 32'(32'h28 + (c - 14) * 4), word_of(4'(10 + c - 14)));
                end
            end
            step();
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_misaligned_wrap();
        do_reset();
        instr_ready = 1'b1;
        redirect_pc = 32'h3E;
        for (int c = 0; c <= 11; c++) begin
            redirect_valid = (c == 5);
            #1;
            if (c == 6) begin
                checks++; if (fetch_error !== 1'b1) begin errors++; $display("FAIL misalign_err_pulse: got %b expected 1", fetch_error); end
                checks++; if (mem_address !== 4'hF) begin errors++; $display("FAIL wrap_addr_f: got %h expected f", mem_address); end
            end
            if (c == 7) begin
                checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL misalign_err_clear: got %b expected 0", fetch_error); end
                checks++; if (mem_address !== 4'h0) begin errors++; $display("FAIL wrap_addr_0: got %h expected 0", mem_address); end
            end
            if (c == 8) begin
                checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL misalign_gap: got %b expected 0", instr_valid); end
            end
            if (c >= 9) begin
                checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'(32'h3C + (c - 9) * 4) || instr_data !== word_of(4'(15 + c - 9))) begin
                    errors++; $display("FAIL wrap_stream c=%0d: got v=%b pc=%h d=%h expected v=1 pc=%h d=%h", c, instr_valid, instr_pc, instr_data, 32'(32'h3C + (c - 9) * 4), word_of(4'(15 + c - 9)));
                end
            end
            step();
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        instr_ready = 1'b1;
        for (int c = 0; c <= 14; c++) begin
            rst_n = (c != 8);
            #1;
            if (c == 8) begin
                checks++; if (mem_read_enable !== 1'b0) begin errors++; $display("FAIL rstmid_rden: got %b expected 0", mem_read_enable); end
            end
            if (c >= 9 && c <= 11) begin
                checks++; if (instr_valid !== 1'b0 || instr_data !== 32'h0) begin errors++; $display("FAIL rstmid_quiet c=%0d: got v=%b d=%h expected v=0 d=0", c, instr_valid, instr_data); end
            end
            if (c >= 12) begin
                checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'((c - 12) * 4) || instr_data !== word_of(4'(c - 12))) begin
                    errors++; $display("FAIL rstmid_restart c=%0d: got v=%b pc=%h d=%h expected v=1 pc=%h d=%h", c, instr_valid, instr_pc, instr_data, 32'((c - 12) * 4), word_of(4'(c - 12)));
                end
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misaligned_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
